// File: rtl/ysyx_22050854_wb_pkg.sv
// Shared write-back arbiter types and constants.
// Requester order is fixed: ALU, LSU, MDU.
package ysyx_22050854_wb_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int NREQ_DEFAULT = 3;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;

    typedef struct packed {
        logic                    valid;
        logic [4:0]              rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/ysyx_22050854_rr_arbiter.sv
// Round-robin arbiter: pointer register plus one-hot grant search from ptr.
// Latency: grant is combinational; ptr updates on the edge after an advance.
// Backpressure: non-granted requesters simply see no grant and wait.
module ysyx_22050854_rr_arbiter
    import ysyx_22050854_wb_pkg::*;
#(
    parameter int N = NREQ_DEFAULT,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_eff;
    logic          found;

    // Encodings at or beyond N are not reachable in normal use; fold them to 0.
    assign ptr_eff = (int'(ptr) >= N) ? '0 : ptr;

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_eff) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22050854_wb_arbiter.sv
// Shares the register-file write port among ALU/LSU/MDU by round-robin; optional bypass via YSYX_22050854_WB_FWD_EN.
// Latency: transfer in cycle N drives rf_wen/rf_waddr/rf_wdata in cycle N+1.
// Backpressure: no internal storage; losers see req_ready low and hold their request.
module ysyx_22050854_wb_arbiter
    import ysyx_22050854_wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*5-1:0] req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rf_wen,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
`ifdef YSYX_22050854_WB_FWD_EN
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
`endif
    output logic              wb_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_req_t         reqs [NREQ];
    wb_req_t         sel;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            xfer;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqs[i].valid = req_valid[i];
            reqs[i].rd    = req_rd[i*5 +: 5];
            reqs[i].data  = XLEN_DEFAULT'(req_data[i*XLEN +: XLEN]);
            arb_req[i]    = reqs[i].valid;
        end
    end

    ysyx_22050854_rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(gnt_idx) == i) sel = reqs[i];
        end
    end

    assign req_ready = rst ? '0 : gnt;
    assign xfer      = |(req_valid & req_ready);
    assign wb_busy   = |(req_valid & ~req_ready);

`ifdef YSYX_22050854_WB_FWD_EN
    assign fwd_valid = xfer && (sel.rd != 5'd0);
    assign fwd_rd    = sel.rd;
    assign fwd_data  = XLEN'(sel.data);
`endif

    // x0 writes are accepted upstream but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (xfer && (sel.rd != 5'd0)) begin
            rf_wen   <= 1'b1;
            rf_waddr <= sel.rd;
            rf_wdata <= XLEN'(sel.data);
        end else begin
            rf_wen   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_wb_arbiter.sv
// Scoreboard bench for the write-back arbiter: expected register-file writes are
// queued when a grant is driven and popped after the following clock edge.
module tb_ysyx_22050854_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NREQ = 3;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rf_wen;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              wb_busy;
`ifdef YSYX_22050854_WB_FWD_EN
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [XLEN-1:0]   fwd_data;
`endif

    ysyx_22050854_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
`ifdef YSYX_22050854_WB_FWD_EN
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
`endif
        .wb_busy   (wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            wen;
        logic [4:0]      waddr;
        logic [XLEN-1:0] wdata;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    logic [4:0]      m_rd  [NREQ];
    logic [XLEN-1:0] m_dat [NREQ];
    logic [4:0]      last_a;
    logic [XLEN-1:0] last_d;

    task automatic set_req(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
        m_rd[i]  = rd;
        m_dat[i] = d;
        req_rd[i*5 +: 5]        = rd;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    // One clock cycle: drive valid, check grant, queue expected write, check outputs after the edge.
    task automatic cycle(input logic [2:0] valid, input logic [2:0] exp_rdy, input string name);
        exp_t e;
        exp_t got;
        logic exp_busy;
        req_valid = valid;
        #1;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s req_ready got %b want %b", name, req_ready, exp_rdy);
        end
        exp_busy = |(valid & ~exp_rdy);
        checks++;
        if (wb_busy !== exp_busy) begin
            errors++;
            $display("FAIL %s wb_busy got %b want %b", name, wb_busy, exp_busy);
        end
        e = '{wen: 1'b0, waddr: last_a, wdata: last_d};
        for (int i = 0; i < NREQ; i++) begin
            if (exp_rdy[i] && m_rd[i] != 5'd0) begin
                e = '{wen: 1'b1, waddr: m_rd[i], wdata: m_dat[i]};
                last_a = m_rd[i];
                last_d = m_dat[i];
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty got size 0 want 1", name);
        end else begin
            e = sb.pop_front();
            got = '{wen: rf_wen, waddr: rf_waddr, wdata: rf_wdata};
            if (got !== e) begin
                errors++;
                $display("FAIL %s rf got wen=%b a=%0d d=%h want wen=%b a=%0d d=%h",
                         name, rf_wen, rf_waddr, rf_wdata, e.wen, e.waddr, e.wdata);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 3'b111;
        #3;
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got %b want 000", req_ready);
        end
        checks++;
        if ({rf_wen, rf_waddr, rf_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_regs got wen=%b a=%0d d=%h want all zero", rf_wen, rf_waddr, rf_wdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_a = '0;
        last_d = '0;
    endtask

    task automatic test_alu_single();
        set_req(0, 5'd5, 64'hDEAD);
        cycle(3'b001, 3'b001, "alu_single");
        cycle(3'b000, 3'b000, "alu_idle");
    endtask

    task automatic test_all_three();
        // Walk ptr from 1 back to 0 with single LSU then MDU transfers.
        set_req(1, 5'd9, 64'h0909);
        cycle(3'b010, 3'b010, "lsu_single");
        set_req(2, 5'd10, 64'h1010);
        cycle(3'b100, 3'b100, "mdu_single");
        set_req(0, 5'd1, 64'hA1);
        set_req(1, 5'd2, 64'hB2);
        set_req(2, 5'd3, 64'hC3);
        cycle(3'b111, 3'b001, "all3_alu");
        cycle(3'b110, 3'b010, "all3_lsu");
        cycle(3'b100, 3'b100, "all3_mdu");
        cycle(3'b000, 3'b000, "all3_idle");
    endtask

    task automatic test_lsu_mdu_ptr2();
        set_req(1, 5'd11, 64'h1111);
        cycle(3'b010, 3'b010, "to_ptr2");
        set_req(1, 5'd12, 64'h1212);
        set_req(2, 5'd13, 64'h1313);
        cycle(3'b110, 3'b100, "ptr2_mdu_first");
        cycle(3'b010, 3'b010, "ptr2_lsu_second");
        set_req(0, 5'd14, 64'h1414);
        set_req(1, 5'd15, 64'h1515);
        set_req(2, 5'd16, 64'h1616);
        cycle(3'b111, 3'b100, "ptr_back_at_2");
        cycle(3'b011, 3'b001, "wrap_to_alu");
        cycle(3'b010, 3'b010, "drain_lsu");
    endtask

    task automatic test_x0();
        set_req(2, 5'd0, 64'h1234);
        cycle(3'b100, 3'b100, "x0_accept");
        set_req(0, 5'd17, 64'h1717);
        set_req(1, 5'd18, 64'h1818);
        set_req(2, 5'd19, 64'h1919);
        cycle(3'b111, 3'b001, "x0_ptr_at_0");
        cycle(3'b110, 3'b010, "x0_drain_lsu");
        cycle(3'b100, 3'b100, "x0_drain_mdu");
    endtask

    task automatic test_async_reset();
        set_req(0, 5'd4, 64'hBEEF);
        set_req(1, 5'd20, 64'h2020);
        cycle(3'b001, 3'b001, "pre_reset_grant");
        req_valid = 3'b000;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rf_wen, rf_waddr, rf_wdata} !== '0) begin
            errors++;
            $display("FAIL async_reset_regs got wen=%b a=%0d d=%h want all zero", rf_wen, rf_waddr, rf_wdata);
        end
        req_valid = 3'b111;
        #1;
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_ready got %b want 000", req_ready);
        end
        checks++;
        if (wb_busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_busy got %b want 1", wb_busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_a = '0;
        last_d = '0;
        sb.delete();
        set_req(0, 5'd21, 64'h2121);
        cycle(3'b011, 3'b001, "post_reset_ptr0");
        cycle(3'b010, 3'b010, "post_reset_lsu");
    endtask

`ifdef YSYX_22050854_WB_FWD_EN
    task automatic test_fwd();
        set_req(1, 5'd7, 64'h55);
        req_valid = 3'b010;
        #1;
        checks++;
        if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd7, 64'h55}) begin
            errors++;
            $display("FAIL fwd got v=%b rd=%0d d=%h want v=1 rd=7 d=55", fwd_valid, fwd_rd, fwd_data);
        end
        cycle(3'b010, 3'b010, "fwd_lsu");
        set_req(0, 5'd0, 64'h99);
        req_valid = 3'b001;
        #1;
        checks++;
        if (fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_x0 got v=%b want 0", fwd_valid);
        end
        cycle(3'b001, 3'b001, "fwd_x0_xfer");
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_rd = '0;
        req_data = '0;
        last_a = '0;
        last_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_rd[i] = '0;
            m_dat[i] = '0;
        end
        test_reset();
        test_alu_single();
        test_all_three();
        test_lsu_mdu_ptr2();
        test_x0();
        test_async_reset();
`ifdef YSYX_22050854_WB_FWD_EN
        test_fwd();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050854_wb_arbiter.md
# ysyx_22050854_wb_arbiter

Write-back port arbiter for the NPC core. It shares the single register-file write port among three result producers: the ALU path, the load/store unit and the multiply/divide unit. It does this with a valid/ready handshake and a round-robin grant. The granted result is registered and driven onto the RegisterFile write port (`wen`/`waddr`/`wdata`). The block sits between the execute/memory stages and the register file, in place of a direct write-back mux.

## Interface
- `XLEN`, 64, data width of results and register-file write data
- `NREQ`, 3, number of requesters; fixed order: 0 = ALU, 1 = LSU, 2 = MDU
- `clk`  in  1  single core clock, rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `req_valid`  in  NREQ  per-requester result valid
- `req_rd`  in  NREQ*5  per-requester destination register, packed with requester i at bits [5i+4:5i]
- `req_data`  in  NREQ*XLEN  per-requester result data, packed the same way
- `req_ready`  out  NREQ  per-requester accept; at most one bit is high in any cycle
- `rf_wen`  out  1  register-file write enable
- `rf_waddr`  out  5  register-file write address
- `rf_wdata`  out  XLEN  register-file write data
- `wb_busy`  out  1  high when any `req_valid` bit is high and that requester is not granted this cycle (stall hint for the issue stage)

## Operation
- Each cycle, the block grants exactly one valid requester, or none if no request is valid.
- Transfer rule: requester i transfers when `req_valid[i] & req_ready[i]` is high.
- Once a requester asserts valid, it holds `req_valid`, `req_rd` and `req_data` stable until its transfer.
- Arbitration is round-robin with a 2-bit priority pointer `ptr`:
  - The search starts at index `ptr` and wraps modulo NREQ; the first valid requester wins.
  - After a transfer by requester k, `ptr` becomes `(k+1) mod NREQ`.
  - With no transfer, `ptr` holds.
- Worst-case wait for a continuously valid requester is NREQ-1 cycles.
- Writes to x0: the block accepts them (`req_ready` high, pointer advances), but `rf_wen` stays low on the following cycle.
- Output register update:
  - On a transfer with `rd != 0`: `rf_wen <= 1`, `rf_waddr <= rd`, `rf_wdata <= data`.
  - On any other cycle: `rf_wen <= 0`, and `rf_waddr`/`rf_wdata` hold their last values.
- There are no queues inside the block. Back-pressure goes entirely through `req_ready`.

## Timing
- `req_ready` is combinational from `req_valid` and `ptr`. No path from `req_ready` back to `req_valid` is permitted.
- Latency: a transfer in cycle N produces `rf_wen` high in cycle N+1, and the register file captures the value at the end of N+1.
- Throughput is one write per cycle; back-to-back grants are allowed.
- Reset values: `rf_wen=0`, `rf_waddr=0`, `rf_wdata=0`, `ptr=0` (ALU first). `req_ready` is 0 while `rst` is high.
- Reset asserted mid-operation: all registers clear immediately. An in-flight `rf_wen` is dropped, and requesters re-present their results after reset.
- Simultaneous requests: the winner is decided only by `ptr`, so a low index has no inherent advantage.
- Pointer wrap: after a grant to index NREQ-1, `ptr` returns to 0. Unused `ptr` encodings (≥ NREQ) are treated as 0.

## Configuration
- `YSYX_22050854_WB_FWD_EN` adds outputs `fwd_valid` (1), `fwd_rd` (5) and `fwd_data` (XLEN).
  - These are a combinational copy of the transfer happening this cycle (winner's rd/data; `fwd_valid` is low for rd=0).
  - The decode stage uses them to bypass the one-cycle register-file write latency.
- Without the macro: the ports are absent, and consumers must wait until cycle N+2 to read the new value from the register file.

## Structure
- Shared package `ysyx_22050854_wb_pkg` holds:
  - `XLEN_DEFAULT` and `NREQ_DEFAULT`
  - requester index constants `WB_ALU=0`, `WB_LSU=1`, `WB_MDU=2`
  - typedef `wb_req_t` {valid, rd[4:0], data[XLEN-1:0]}
- Sub-module `ysyx_22050854_rr_arbiter` (parameter N) contains the pointer register and grant logic:
  - inputs: `req[N-1:0]`, `advance`
  - outputs: one-hot `gnt[N-1:0]`, `gnt_idx`
- The top level does the data mux, x0 suppression and output registers.

## Test plan
- Reset, then ALU only: `req_valid=001`, rd=5, data=0xDEAD -> `req_ready=001` the same cycle; next cycle `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0xDEAD`.
- All three valid and held for 3 cycles, starting from `ptr=0` -> grants in order ALU, LSU, MDU, one per cycle; `rf_wen` high for 3 consecutive cycles starting one cycle later.
- LSU and MDU valid with `ptr=2` -> MDU granted first, then LSU; after that, `ptr=2`.
- MDU valid with rd=0, data=0x1234 -> `req_ready[2]=1`; next cycle `rf_wen=0`; `ptr` advances to 0.
- `rst` pulsed asynchronously in the cycle after a grant -> `rf_wen` drops to 0 immediately, `ptr=0`, `req_ready=000` while `rst` is high.
- With `YSYX_22050854_WB_FWD_EN`: LSU transfers rd=7, data=0x55 -> `fwd_valid=1`, `fwd_rd=7`, `fwd_data=0x55` in the transfer cycle.
